tcp_tx_pattern_gen: RTL

//  Test-data source feeding SiTCP TCP transmit port (TCP_TX_WR/TCP_TX_DATA), throttled by TCP_TX_FULL.

---
 rtl/tcp_txgen_pkg.sv | 57 +++++
 rtl/tcp_txgen_regs.sv | 118 +++++++++++
 rtl/tcp_tx_pattern_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tcp_txgen_pkg.sv
// ----------------------------------------------------------------------------
// tcp_txgen_pkg
// Shared definitions for the SiTCP TX pattern generator:
//   - RBCP register window offsets (16-byte window)
//   - CTRL register bit indices
//   - FSM state encoding
//   - PRBS-7 tap constant and byte-step helper (TXGEN_PRBS_EN only)
// Configuration macro: TXGEN_PRBS_EN enables the PRBS-7 pattern helpers.
// ----------------------------------------------------------------------------
package tcp_txgen_pkg;

    // Register offsets inside the window; multi-byte registers are big-endian
    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_LEN3   = 4'h1;
    localparam logic [3:0] OFS_LEN2   = 4'h2;
    localparam logic [3:0] OFS_LEN1   = 4'h3;
    localparam logic [3:0] OFS_LEN0   = 4'h4;
    localparam logic [3:0] OFS_SEED   = 4'h5;
    localparam logic [3:0] OFS_STATUS = 4'h6;
    localparam logic [3:0] OFS_SENT3  = 4'h8;
    localparam logic [3:0] OFS_SENT2  = 4'h9;
    localparam logic [3:0] OFS_SENT1  = 4'hA;
    localparam logic [3:0] OFS_SENT0  = 4'hB;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_STOP  = 2;
    localparam int CTRL_PRBS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } txgen_state_t;

`ifdef TXGEN_PRBS_EN
    // x^7 + x^6 + 1: feedback from bits 6 and 5 of a left-shifting register
    localparam logic [6:0] PRBS7_TAPS      = 7'b110_0000;
    localparam logic [6:0] PRBS7_ZERO_SEED = 7'h7F;

    // Runs eight LFSR steps; returns {next_state[6:0], byte[7:0]} where the
    // byte collects the shifted-out MSBs, first bit out ends up as bit 7.
    function automatic logic [14:0] prbs7_byte(input logic [6:0] state);
        logic [6:0] s;
        logic [7:0] b;
        s = state;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], s[6]};
            s = {s[5:0], ^(s & PRBS7_TAPS)};
        end
        return {s, b};
    endfunction
`endif

endpackage

// File: rtl/tcp_txgen_regs.sv
// ----------------------------------------------------------------------------
// tcp_txgen_regs
// RBCP decode and register file for the TX pattern generator.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   RBCP_ADDR/WE/RE/WD       RBCP bus from SiTCP
//   RBCP_ACK, RBCP_RD        acknowledge + read data, one cycle after strobe
//   stat_busy/done/abort     live status bits from the FSM
//   stat_sent                live byte counter from the datapath
//   start_pulse, stop_pulse  one-cycle command pulses decoded from CTRL writes
//   reg_cont, reg_prbs       CTRL mode bits
//   reg_len, reg_seed        programmed run length and pattern seed
// Configuration macro: TXGEN_PRBS_EN keeps CTRL.b3 (PRBS select); when
// undefined the bit is ignored on write and reads back 0.
// ----------------------------------------------------------------------------
module tcp_txgen_regs
    import tcp_txgen_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100,
    parameter logic [7:0]  DEF_SEED  = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] RBCP_ADDR,
    input  logic        RBCP_WE,
    input  logic        RBCP_RE,
    input  logic [7:0]  RBCP_WD,
    output logic        RBCP_ACK,
    output logic [7:0]  RBCP_RD,
    input  logic        stat_busy,
    input  logic        stat_done,
    input  logic        stat_abort,
    input  logic [31:0] stat_sent,
    output logic        start_pulse,
    output logic        stop_pulse,
    output logic        reg_cont,
    output logic        reg_prbs,
    output logic [31:0] reg_len,
    output logic [7:0]  reg_seed
);

    logic       in_window;
    logic [3:0] offset;
    logic [7:0] rd_mux;

    assign in_window = (RBCP_ADDR[31:4] == BASE_ADDR[31:4]);
    assign offset    = RBCP_ADDR[3:0];

`ifdef TXGEN_PRBS_EN
    logic prbs_q;
    assign reg_prbs = prbs_q;
`else
    logic unused_prbs_wd;
    assign reg_prbs       = 1'b0;
    assign unused_prbs_wd = RBCP_WD[CTRL_PRBS];
`endif

    // Read mux; unmapped offsets return zero
    always_comb begin
        rd_mux = 8'h00;
        case (offset)
            OFS_CTRL:   rd_mux = {4'b0000, reg_prbs, 1'b0, reg_cont, 1'b0};
            OFS_LEN3:   rd_mux = reg_len[31:24];
            OFS_LEN2:   rd_mux = reg_len[23:16];
            OFS_LEN1:   rd_mux = reg_len[15:8];
            OFS_LEN0:   rd_mux = reg_len[7:0];
            OFS_SEED:   rd_mux = reg_seed;
            OFS_STATUS: rd_mux = {5'b00000, stat_abort, stat_done, stat_busy};
            OFS_SENT3:  rd_mux = stat_sent[31:24];
            OFS_SENT2:  rd_mux = stat_sent[23:16];
            OFS_SENT1:  rd_mux = stat_sent[15:8];
            OFS_SENT0:  rd_mux = stat_sent[7:0];
            default:    rd_mux = 8'h00;
        endcase
    end

    // Register writes, ACK/RD generation and command pulses. START/STOP are
    // registered together with the CONT/PRBS bits, so the FSM sees the mode
    // bits from the same write when it acts on the pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RBCP_ACK    <= 1'b0;
            RBCP_RD     <= 8'h00;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            reg_cont    <= 1'b0;
            reg_len     <= 32'h0000_0000;
            reg_seed    <= DEF_SEED;
`ifdef TXGEN_PRBS_EN
            prbs_q      <= 1'b0;
`endif
        end else begin
            RBCP_ACK    <= in_window & (RBCP_WE | RBCP_RE);
            RBCP_RD     <= (in_window & (RBCP_WE | RBCP_RE)) ? rd_mux : 8'h00;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            if (in_window && RBCP_WE) begin
                case (offset)
                    OFS_CTRL: begin
                        start_pulse <= RBCP_WD[CTRL_START];
                        stop_pulse  <= RBCP_WD[CTRL_STOP];
                        reg_cont    <= RBCP_WD[CTRL_CONT];
`ifdef TXGEN_PRBS_EN
                        prbs_q      <= RBCP_WD[CTRL_PRBS];
`endif
                    end
                    OFS_LEN3: reg_len[31:24] <= RBCP_WD;
                    OFS_LEN2: reg_len[23:16] <= RBCP_WD;
                    OFS_LEN1: reg_len[15:8]  <= RBCP_WD;
                    OFS_LEN0: reg_len[7:0]   <= RBCP_WD;
                    OFS_SEED: reg_seed       <= RBCP_WD;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/tcp_tx_pattern_gen.sv
// ----------------------------------------------------------------------------
// tcp_tx_pattern_gen
// Test-data source for the SiTCP TCP transmit port, used for throughput
// testing instead of the RX->TX FIFO loopback. Streams a fixed-length or
// continuous byte pattern while the TCP connection is open, throttled by
// TCP_TX_FULL, and is controlled through a 16-byte RBCP register window.
// Ports:
//   CLK, RST                  200 MHz clock, synchronous active-high reset
//   TCP_OPEN_ACK              connection open
//   TCP_TX_FULL               SiTCP TX almost-full
//   TCP_TX_WR, TCP_TX_DATA    registered byte write strobe and data
//   RBCP_ADDR/WE/RE/WD        RBCP access
//   RBCP_ACK, RBCP_RD         RBCP acknowledge and read data
//   BUSY                      high while a run is in progress (LED)
// Configuration macro: TXGEN_PRBS_EN adds the PRBS-7 pattern selected by
// CTRL.b3; without it only the counting pattern exists.
// ----------------------------------------------------------------------------
module tcp_tx_pattern_gen
    import tcp_txgen_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100,
    parameter logic [7:0]  DEF_SEED  = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TCP_OPEN_ACK,
    input  logic        TCP_TX_FULL,
    output logic        TCP_TX_WR,
    output logic [7:0]  TCP_TX_DATA,
    input  logic [31:0] RBCP_ADDR,
    input  logic        RBCP_WE,
    input  logic        RBCP_RE,
    input  logic [7:0]  RBCP_WD,
    output logic        RBCP_ACK,
    output logic [7:0]  RBCP_RD,
    output logic        BUSY
);

    logic         start_pulse;
    logic         stop_pulse;
    logic         reg_cont;
    logic         reg_prbs;
    logic [31:0]  reg_len;
    logic [7:0]   reg_seed;

    txgen_state_t state;
    logic         run_cont;
    logic [31:0]  remaining;
    logic [7:0]   pat_cnt;
    logic [31:0]  sent;
    logic         done_flag;
    logic         abort_flag;

`ifdef TXGEN_PRBS_EN
    logic         run_prbs;
    logic [6:0]   lfsr;
    logic [14:0]  prbs_step;
    assign prbs_step = prbs7_byte(lfsr);
`else
    logic         unused_prbs_sel;
    assign unused_prbs_sel = reg_prbs;
`endif

    tcp_txgen_regs #(
        .BASE_ADDR (BASE_ADDR),
        .DEF_SEED  (DEF_SEED)
    ) u_regs (
        .CLK         (CLK),
        .RST         (RST),
        .RBCP_ADDR   (RBCP_ADDR),
        .RBCP_WE     (RBCP_WE),
        .RBCP_RE     (RBCP_RE),
        .RBCP_WD     (RBCP_WD),
        .RBCP_ACK    (RBCP_ACK),
        .RBCP_RD     (RBCP_RD),
        .stat_busy   (BUSY),
        .stat_done   (done_flag),
        .stat_abort  (abort_flag),
        .stat_sent   (sent),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .reg_cont    (reg_cont),
        .reg_prbs    (reg_prbs),
        .reg_len     (reg_len),
        .reg_seed    (reg_seed)
    );

    // Run-control FSM and byte datapath. TCP_TX_WR is decided from the FULL
    // value sampled at this edge, so a FULL cycle is never followed by a
    // write. STOP and connection loss both abort; STOP beats a simultaneous
    // START. Run parameters are latched on START so later register writes
    // do not disturb the run in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            TCP_TX_WR   <= 1'b0;
            TCP_TX_DATA <= 8'h00;
            BUSY        <= 1'b0;
            run_cont    <= 1'b0;
            remaining   <= 32'h0000_0000;
            pat_cnt     <= 8'h00;
            sent        <= 32'h0000_0000;
            done_flag   <= 1'b0;
            abort_flag  <= 1'b0;
`ifdef TXGEN_PRBS_EN
            run_prbs    <= 1'b0;
            lfsr        <= PRBS7_ZERO_SEED;
`endif
        end else begin
            TCP_TX_WR <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (stop_pulse || !TCP_OPEN_ACK) begin
                        state      <= ST_IDLE;
                        BUSY       <= 1'b0;
                        abort_flag <= 1'b1;
                    end else if (!run_cont && remaining == 32'h0000_0000) begin
                        state     <= ST_DONE;
                        BUSY      <= 1'b0;
                        done_flag <= 1'b1;
                    end else if (!TCP_TX_FULL) begin
                        TCP_TX_WR <= 1'b1;
                        sent      <= sent + 32'd1;
                        if (!run_cont) begin
                            remaining <= remaining - 32'd1;
                        end
`ifdef TXGEN_PRBS_EN
                        if (run_prbs) begin
                            TCP_TX_DATA <= prbs_step[7:0];
                            lfsr        <= prbs_step[14:8];
                        end else begin
                            TCP_TX_DATA <= pat_cnt;
                            pat_cnt     <= pat_cnt + 8'd1;
                        end
`else
                        TCP_TX_DATA <= pat_cnt;
                        pat_cnt     <= pat_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    if (start_pulse && !stop_pulse && TCP_OPEN_ACK) begin
                        state      <= ST_RUN;
                        BUSY       <= 1'b1;
                        run_cont   <= reg_cont;
                        remaining  <= reg_len;
                        pat_cnt    <= reg_seed;
                        sent       <= 32'h0000_0000;
                        done_flag  <= 1'b0;
                        abort_flag <= 1'b0;
`ifdef TXGEN_PRBS_EN
                        run_prbs   <= reg_prbs;
                        lfsr       <= (reg_seed[6:0] == 7'h00) ? PRBS7_ZERO_SEED : reg_seed[6:0];
`endif
                    end
                end
            endcase
        end
    end

endmodule
